// File: rtl/cdc_xfer_arb_pkg.sv
// Shared types and constants for cdc_xfer_arb.
// With CDC_XFER_TIMEOUT_EN defined, the RECOVER state is part of the FSM encoding.
package cdc_xfer_pkg;

  localparam int CNT_W = $clog2(65536);

  typedef enum logic [1:0] {
    ST_IDLE,
`ifdef CDC_XFER_TIMEOUT_EN
    ST_WAIT_ACK,
    ST_RECOVER
`else
    ST_WAIT_ACK
`endif
  } state_t;

endpackage

// File: rtl/cdc_xfer_arb_if.sv
// Bus bundle between requesters/far domain (master) and cdc_xfer_arb (slave).
interface cdc_xfer_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        grant;
  logic [NUM_REQ-1:0]        done;
  logic [DATA_W-1:0]         xfer_data;
  logic                      xfer_tgl;
  logic                      ack_tgl;
  logic                      busy;
  logic                      err;
  logic                      err_clr;

  modport master (
    output req, req_data, ack_tgl, err_clr,
    input  grant, done, xfer_data, xfer_tgl, busy, err
  );

  modport slave (
    input  req, req_data, ack_tgl, err_clr,
    output grant, done, xfer_data, xfer_tgl, busy, err
  );
endinterface

// File: rtl/cdc_xfer_arb_toggle_sync.sv
// Two-flop toggle synchronizer; sig_sync is the level, pulse_sync marks each edge.
module toggle_sync (
  input  logic clk,
  input  logic rst_b,
  input  logic sig_in,
  output logic sig_sync,
  output logic pulse_sync
);
  logic r_sync_p0, r_sync_p1, r_sync_p2;

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      r_sync_p0 <= 1'b0;
      r_sync_p1 <= 1'b0;
      r_sync_p2 <= 1'b0;
    end else begin
      r_sync_p0 <= sig_in;
      r_sync_p1 <= r_sync_p0;
      r_sync_p2 <= r_sync_p1;
    end
  end

  assign sig_sync   = r_sync_p1;
  assign pulse_sync = r_sync_p1 ^ r_sync_p2;
endmodule

// File: rtl/cdc_xfer_arb.sv
// Round-robin arbiter that hands one word at a time to a far clock domain via a toggle handshake.
// Define CDC_XFER_TIMEOUT_EN to add the acknowledge timeout, RECOVER state and sticky err flag.
module cdc_xfer_arb
  import cdc_xfer_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input logic           clk,
  input logic           rst_n,
  cdc_xfer_arb_if.slave io
);
  localparam int IDX_W = $clog2(NUM_REQ);

  state_t             r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_grant, r_done;
  logic [DATA_W-1:0]  r_xfer_data;
  logic               r_xfer_tgl;
  logic [IDX_W-1:0]   r_last_win;
  logic               r_have_win;
  logic [IDX_W-1:0]   w_start, w_win;
  logic [IDX_W:0]     w_idx;
  logic               w_found, w_capture, w_done_set;
  logic               w_ack_sync, w_match;

  // Only the level is compared; both toggle edges carry meaning, so the pulse output stays open.
  toggle_sync u_ack_sync (
    .clk        (clk),
    .rst_b      (~rst_n),
    .sig_in     (io.ack_tgl),
    .sig_sync   (w_ack_sync),
    .pulse_sync ()
  );

  assign w_match = (w_ack_sync == r_xfer_tgl);

  // Search starts one past the last winner; before any grant it starts at 0.
  always_comb begin
    w_start = '0;
    w_win   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    if (r_have_win && (r_last_win != IDX_W'(NUM_REQ - 1)))
      w_start = r_last_win + IDX_W'(1);
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = {1'b0, w_start} + (IDX_W+1)'(k);
      if (w_idx >= (IDX_W+1)'(NUM_REQ))
        w_idx = w_idx - (IDX_W+1)'(NUM_REQ);
      if (!w_found && io.req[w_idx[IDX_W-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[IDX_W-1:0];
      end
    end
  end

`ifdef CDC_XFER_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic             w_timeout;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_done_set  = 1'b0;
`ifdef CDC_XFER_TIMEOUT_EN
    w_timeout   = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_WAIT_ACK;
          w_capture   = 1'b1;
        end
      end
      ST_WAIT_ACK: begin
        if (w_match) begin
          w_state_nxt = ST_IDLE;
          w_done_set  = 1'b1;
        end
`ifdef CDC_XFER_TIMEOUT_EN
        else if (r_cnt >= CNT_W'(TIMEOUT - 1)) begin
          w_state_nxt = ST_RECOVER;
          w_timeout   = 1'b1;
        end
`endif
      end
`ifdef CDC_XFER_TIMEOUT_EN
      ST_RECOVER: begin
        if (w_match) w_state_nxt = ST_IDLE;
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_grant     <= '0;
      r_done      <= '0;
      r_xfer_data <= '0;
      r_xfer_tgl  <= 1'b0;
      r_last_win  <= '0;
      r_have_win  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= '0;
      r_done  <= '0;
      if (w_capture) begin
        r_grant     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;
        r_xfer_data <= io.req_data[w_win*DATA_W +: DATA_W];
        r_xfer_tgl  <= ~r_xfer_tgl;
        r_last_win  <= w_win;
        r_have_win  <= 1'b1;
      end
      if (w_done_set)
        r_done <= {{(NUM_REQ-1){1'b0}}, 1'b1} << r_last_win;
    end
  end

`ifdef CDC_XFER_TIMEOUT_EN
  // Timeout set takes priority over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_capture)
        r_cnt <= '0;
      else if ((r_state == ST_WAIT_ACK) && (r_cnt != '1))
        r_cnt <= r_cnt + CNT_W'(1);
      if (w_timeout)
        r_err <= 1'b1;
      else if (io.err_clr)
        r_err <= 1'b0;
    end
  end
  assign io.err = r_err;
`else
  assign io.err = 1'b0;
`endif

  assign io.grant     = r_grant;
  assign io.done      = r_done;
  assign io.xfer_data = r_xfer_data;
  assign io.xfer_tgl  = r_xfer_tgl;
  assign io.busy      = (r_state != ST_IDLE);
endmodule

// File: tb/tb_cdc_xfer_arb.sv
// Directed bench for cdc_xfer_arb; timeout checks run when CDC_XFER_TIMEOUT_EN is defined.
module tb_cdc_xfer_arb;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_bad;

  cdc_xfer_arb_if #(.NUM_REQ(4), .DATA_W(16)) bus ();

  cdc_xfer_arb #(.NUM_REQ(4), .DATA_W(16), .TIMEOUT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Far domain echoes the toggle; done must appear exactly 3 edges later.
  task automatic ack_done(input logic [3:0] exp_done);
    bus.ack_tgl = ~bus.ack_tgl;
    tick();
    chk("done_wait1", 32'(bus.done), 32'h0);
    tick();
    chk("done_wait2", 32'(bus.done), 32'h0);
    chk("busy_wait", 32'(bus.busy), 32'h1);
    tick();
    chk("done_pulse", 32'(bus.done), 32'(exp_done));
    chk("grant_in_done", 32'(bus.grant), 32'h0);
    chk("busy_done", 32'(bus.busy), 32'h0);
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    bus.req     = '0;
    bus.ack_tgl = 1'b0;
    bus.err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    logic [3:0] exp_g;
    n_chk       = 0;
    n_bad       = 0;
    rst_n       = 1'b0;
    bus.req     = '0;
    bus.req_data = '0;
    bus.ack_tgl = 1'b0;
    bus.err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", 32'(bus.grant), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    chk("rst_data", 32'(bus.xfer_data), 32'h0);
    chk("rst_tgl", 32'(bus.xfer_tgl), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_err", 32'(bus.err), 32'h0);
    rst_n = 1'b1;
    tick();

    // Single transfer from requester 0, ack after 4 cycles
    bus.req_data = {16'h4444, 16'h3333, 16'h2222, 16'hA5A5};
    bus.req      = 4'b0001;
    tick();
    chk("t1_grant", 32'(bus.grant), 32'h1);
    chk("t1_data", 32'(bus.xfer_data), 32'hA5A5);
    chk("t1_tgl", 32'(bus.xfer_tgl), 32'h1);
    chk("t1_busy", 32'(bus.busy), 32'h1);
    bus.req = 4'b0000;
    repeat (4) begin
      tick();
      chk("t1_nodone", 32'(bus.done), 32'h0);
    end
    ack_done(4'b0001);
    tick();
    chk("t1_done_clear", 32'(bus.done), 32'h0);

    // Round robin with all requesters held
    do_reset();
    bus.req_data = {16'hD3D3, 16'hD2D2, 16'hD1D1, 16'hD0D0};
    bus.req      = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      exp_g = 4'b0001 << (i % 4);
      tick();
      chk("rr_grant", 32'(bus.grant), 32'(exp_g));
      chk("rr_data", 32'(bus.xfer_data), 32'({2{4'hD, 4'(i % 4)}}));
      ack_done(exp_g);
    end
    // Last winner 0: search starts at 1, then wraps to 0
    bus.req = 4'b0101;
    tick();
    chk("rr_skip_grant", 32'(bus.grant), 32'h4);
    chk("rr_skip_data", 32'(bus.xfer_data), 32'hD2D2);
    ack_done(4'b0100);
    tick();
    chk("rr_wrap_grant", 32'(bus.grant), 32'h1);
    ack_done(4'b0001);
    bus.req = 4'b0000;
    tick();

    // Reset during a transfer abandons it
    bus.req = 4'b0001;
    tick();
    chk("mid_grant", 32'(bus.grant), 32'h1);
    bus.req     = 4'b0000;
    rst_n       = 1'b0;
    bus.ack_tgl = 1'b0;
    #1;
    chk("mid_rst_grant", 32'(bus.grant), 32'h0);
    chk("mid_rst_data", 32'(bus.xfer_data), 32'h0);
    chk("mid_rst_tgl", 32'(bus.xfer_tgl), 32'h0);
    chk("mid_rst_busy", 32'(bus.busy), 32'h0);
    chk("mid_rst_done", 32'(bus.done), 32'h0);
    chk("mid_rst_err", 32'(bus.err), 32'h0);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    bus.req = 4'b0100;
    tick();
    chk("post_rst_grant", 32'(bus.grant), 32'h4);
    chk("post_rst_data", 32'(bus.xfer_data), 32'hD2D2);
    bus.req = 4'b0000;
    ack_done(4'b0100);
    tick();

`ifdef CDC_XFER_TIMEOUT_EN
    // Ack never returns: err after 8 WAIT_ACK cycles, late ack recovers silently
    bus.req = 4'b0001;
    tick();
    chk("to_grant", 32'(bus.grant), 32'h1);
    bus.req = 4'b0000;
    repeat (7) begin
      tick();
      chk("to_err_early", 32'(bus.err), 32'h0);
    end
    tick();
    chk("to_err_set", 32'(bus.err), 32'h1);
    chk("to_no_done", 32'(bus.done), 32'h0);
    chk("to_busy", 32'(bus.busy), 32'h1);
    repeat (3) begin
      tick();
      chk("rec_busy", 32'(bus.busy), 32'h1);
      chk("rec_no_done", 32'(bus.done), 32'h0);
    end
    bus.ack_tgl = ~bus.ack_tgl;
    repeat (2) begin
      tick();
      chk("rec_wait_busy", 32'(bus.busy), 32'h1);
    end
    tick();
    chk("rec_idle", 32'(bus.busy), 32'h0);
    chk("rec_exit_no_done", 32'(bus.done), 32'h0);
    chk("rec_err_sticky", 32'(bus.err), 32'h1);
    bus.err_clr = 1'b1;
    tick();
    chk("err_cleared", 32'(bus.err), 32'h0);
    bus.err_clr = 1'b0;

    // Ack match in the timeout cycle: done wins, err stays 0
    bus.req = 4'b0001;
    tick();
    bus.req = 4'b0000;
    repeat (5) tick();
    ack_done(4'b0001);
    chk("race_err", 32'(bus.err), 32'h0);

    // One cycle later: timeout wins, and set beats a simultaneous clear
    bus.req = 4'b0001;
    tick();
    bus.req = 4'b0000;
    repeat (6) tick();
    bus.ack_tgl = ~bus.ack_tgl;
    tick();
    chk("late_err_pre", 32'(bus.err), 32'h0);
    bus.err_clr = 1'b1;
    tick();
    chk("set_beats_clr", 32'(bus.err), 32'h1);
    chk("late_no_done", 32'(bus.done), 32'h0);
    chk("late_busy", 32'(bus.busy), 32'h1);
    bus.err_clr = 1'b0;
    tick();
    chk("late_rec_idle", 32'(bus.busy), 32'h0);
    chk("late_rec_no_done", 32'(bus.done), 32'h0);
`else
    // No timeout: waits as long as the ack is withheld
    bus.req = 4'b0001;
    tick();
    chk("hold_grant", 32'(bus.grant), 32'h1);
    bus.req = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      repeat (1000) tick();
      chk("hold_busy", 32'(bus.busy), 32'h1);
      chk("hold_err", 32'(bus.err), 32'h0);
    end
    ack_done(4'b0001);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
